// File: rtl/skin_pkg.sv
// Shared widths, FSM state encoding and the published result record for the
// skin region locator.
package skin_pkg;

    localparam int X_W   = 16;
    localparam int Y_W   = 16;
    localparam int CNT_W = 24;
    localparam int SX_W  = X_W + CNT_W;
    localparam int SY_W  = Y_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [X_W-1:0]   xMin;
        logic [X_W-1:0]   xMax;
        logic [Y_W-1:0]   yMin;
        logic [Y_W-1:0]   yMax;
        logic [X_W-1:0]   xCent;
        logic [Y_W-1:0]   yCent;
        logic             found;
    } result_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock; done_o is a
// single-cycle pulse one cycle after the last iteration.
module seq_divider #(
    parameter int N   = 40,
    parameter int D_W = 24,
    parameter int Q_W = N
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic [Q_W-1:0] quotient_o,
    output logic           done_o
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   quo_q, quo_d;
    logic [D_W:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [D_W+1:0] shifted;
    logic [D_W+1:0] diff;
    logic           fits;

    // The dividend register doubles as the quotient: bits shift out at the top
    // into the partial remainder while quotient bits shift in at the bottom.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {2'b00, divisor_i};
        fits    = ~diff[D_W+1];
        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            cnt_d  = CW'(N);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = fits ? diff[D_W:0] : shifted[D_W:0];
            quo_d = {quo_q[N-2:0], fits};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // The centroid never exceeds the largest coordinate, so truncation is lossless.
    assign quotient_o = quo_q[Q_W-1:0];
    assign done_o     = done_q;

endmodule

// File: rtl/skin_region_locator.sv
// Accumulates a frame's skin mask into count, sums and bounding box, then
// publishes count, bbox and integer centroid while the next frame accumulates.
module skin_region_locator #(
    parameter int X_W        = 16,
    parameter int Y_W        = 16,
    parameter int CNT_W      = 24,
    parameter int MIN_PIXELS = 64
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iBinary,
    input  logic             iDVAL,
    input  logic [X_W-1:0]   iX_Cont,
    input  logic [Y_W-1:0]   iY_Cont,
    input  logic             iFrame_En,
    output logic [CNT_W-1:0] oCount,
    output logic [X_W-1:0]   oX_Min,
    output logic [X_W-1:0]   oX_Max,
    output logic [Y_W-1:0]   oY_Min,
    output logic [Y_W-1:0]   oY_Max,
    output logic [X_W-1:0]   oX_Cent,
    output logic [Y_W-1:0]   oY_Cent,
    output logic             oFound,
    output logic             oResult_Valid,
    output logic             oBusy,
    output logic             oOverrun
);

    import skin_pkg::*;

    localparam int SUMX_W = X_W + CNT_W;
    localparam int SUMY_W = Y_W + CNT_W;
    localparam int DIV_N  = (SUMX_W > SUMY_W) ? SUMX_W : SUMY_W;
    localparam int Q_W    = (X_W > Y_W) ? X_W : Y_W;

    logic              frameEn_q;
    logic              frameStart, frameEnd, pixelHit, enough;

    logic [CNT_W-1:0]  count_q;
    logic [SUMX_W-1:0] sumX_q;
    logic [SUMY_W-1:0] sumY_q;
    logic [X_W-1:0]    xMin_q, xMax_q;
    logic [Y_W-1:0]    yMin_q, yMax_q;

    logic [CNT_W-1:0]  opCount_q;
    logic [SUMX_W-1:0] opSumX_q;
    logic [SUMY_W-1:0] opSumY_q;
    logic [X_W-1:0]    opXMin_q, opXMax_q;
    logic [Y_W-1:0]    opYMin_q, opYMax_q;
    logic [X_W-1:0]    xCent_q;

    state_t            state_q, state_d;
    logic              startX_q, goDivX;
    logic              overrun_q;
    result_t           result_q, result_d;

    logic              divStart, divDone;
    logic [DIV_N-1:0]  divDividend;
    logic [Q_W-1:0]    divQuot;

    assign frameStart = iFrame_En & ~frameEn_q;
    assign frameEnd   = ~iFrame_En & frameEn_q;
    assign pixelHit   = iFrame_En & iDVAL & iBinary;
    assign enough     = (count_q >= CNT_W'(MIN_PIXELS));

    // Running accumulators; a frame start folds the clear and the first pixel together.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frameEn_q <= 1'b0;
            count_q   <= '0;
            sumX_q    <= '0;
            sumY_q    <= '0;
            xMin_q    <= '0;
            xMax_q    <= '0;
            yMin_q    <= '0;
            yMax_q    <= '0;
        end else begin
            frameEn_q <= iFrame_En;
            if (frameStart) begin
                count_q <= pixelHit ? CNT_W'(1) : '0;
                sumX_q  <= pixelHit ? SUMX_W'(iX_Cont) : '0;
                sumY_q  <= pixelHit ? SUMY_W'(iY_Cont) : '0;
                xMin_q  <= pixelHit ? iX_Cont : '1;
                xMax_q  <= pixelHit ? iX_Cont : '0;
                yMin_q  <= pixelHit ? iY_Cont : '1;
                yMax_q  <= pixelHit ? iY_Cont : '0;
            end else if (pixelHit) begin
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                    sumX_q  <= sumX_q + SUMX_W'(iX_Cont);
                    sumY_q  <= sumY_q + SUMY_W'(iY_Cont);
                end
                if (iX_Cont < xMin_q) xMin_q <= iX_Cont;
                if (iX_Cont > xMax_q) xMax_q <= iX_Cont;
                if (iY_Cont < yMin_q) yMin_q <= iY_Cont;
                if (iY_Cont > yMax_q) yMax_q <= iY_Cont;
            end
        end
    end

    // Snapshot frees the accumulators for the next frame; the X quotient waits here for Y.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            opCount_q <= '0;
            opSumX_q  <= '0;
            opSumY_q  <= '0;
            opXMin_q  <= '0;
            opXMax_q  <= '0;
            opYMin_q  <= '0;
            opYMax_q  <= '0;
            xCent_q   <= '0;
        end else begin
            if (state_q == IDLE && frameEnd) begin
                opCount_q <= count_q;
                opSumX_q  <= sumX_q;
                opSumY_q  <= sumY_q;
                opXMin_q  <= xMin_q;
                opXMax_q  <= xMax_q;
                opYMin_q  <= yMin_q;
                opYMax_q  <= yMax_q;
            end
            if (state_q == DIV_X && divDone) begin
                xCent_q <= divQuot[X_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        goDivX   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (frameEnd) begin
                    if (enough) begin
                        state_d = DIV_X;
                        goDivX  = 1'b1;
                    end else begin
                        state_d        = PUBLISH;
                        result_d       = '0;
                        result_d.count = count_q;
                    end
                end
            end
            DIV_X: begin
                if (divDone) state_d = DIV_Y;
            end
            DIV_Y: begin
                if (divDone) begin
                    state_d        = PUBLISH;
                    result_d.count = opCount_q;
                    result_d.xMin  = opXMin_q;
                    result_d.xMax  = opXMax_q;
                    result_d.yMin  = opYMin_q;
                    result_d.yMax  = opYMax_q;
                    result_d.xCent = xCent_q;
                    result_d.yCent = divQuot[Y_W-1:0];
                    result_d.found = 1'b1;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            startX_q  <= 1'b0;
            overrun_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q  <= state_d;
            startX_q <= goDivX;
            result_q <= result_d;
            if (frameEnd && state_q != IDLE) overrun_q <= 1'b1;
        end
    end

    // The Y division is launched in the same cycle the X division reports done.
    assign divStart    = startX_q | ((state_q == DIV_X) & divDone);
    assign divDividend = startX_q ? DIV_N'(opSumX_q) : DIV_N'(opSumY_q);

    seq_divider #(
        .N   (DIV_N),
        .D_W (CNT_W),
        .Q_W (Q_W)
    ) u_divider (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .start_i    (divStart),
        .dividend_i (divDividend),
        .divisor_i  (opCount_q),
        .quotient_o (divQuot),
        .done_o     (divDone)
    );

    assign oCount        = result_q.count;
    assign oX_Min        = result_q.xMin;
    assign oX_Max        = result_q.xMax;
    assign oY_Min        = result_q.yMin;
    assign oY_Max        = result_q.yMax;
    assign oX_Cent       = result_q.xCent;
    assign oY_Cent       = result_q.yCent;
    assign oFound        = result_q.found;
    assign oResult_Valid = (state_q == PUBLISH);
    assign oBusy         = (state_q == DIV_X) || (state_q == DIV_Y);
    assign oOverrun      = overrun_q;

endmodule

// File: tb/tb_skin_region_locator.sv
// Randomized scoreboard bench: frames are driven from pixel lists, a list-based
// model predicts each published result, and a monitor checks every pulse.
module tb_skin_region_locator;

    localparam int X_W        = 16;
    localparam int Y_W        = 16;
    localparam int CNT_W      = 24;
    localparam int MIN_PIXELS = 64;
    localparam int FOUND_LAT  = (X_W + CNT_W) + (Y_W + CNT_W) + 4;

    logic             iCLK, iRST, iBinary, iDVAL, iFrame_En;
    logic [X_W-1:0]   iX_Cont;
    logic [Y_W-1:0]   iY_Cont;
    logic [CNT_W-1:0] oCount;
    logic [X_W-1:0]   oX_Min, oX_Max, oX_Cent;
    logic [Y_W-1:0]   oY_Min, oY_Max, oY_Cent;
    logic             oFound, oResult_Valid, oBusy, oOverrun;

    typedef struct {
        int x;
        int y;
        bit dval;
        bit skin;
    } pix_t;

    typedef struct {
        longint count, xMin, xMax, yMin, yMax, xCent, yCent;
        bit     found;
        longint due;
    } exp_t;

    pix_t   frameQ[$];
    exp_t   expQ[$];
    int     compared   = 0;
    int     mismatched = 0;
    longint cycleCnt   = 0;

    skin_region_locator #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .CNT_W      (CNT_W),
        .MIN_PIXELS (MIN_PIXELS)
    ) dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iBinary       (iBinary),
        .iDVAL         (iDVAL),
        .iX_Cont       (iX_Cont),
        .iY_Cont       (iY_Cont),
        .iFrame_En     (iFrame_En),
        .oCount        (oCount),
        .oX_Min        (oX_Min),
        .oX_Max        (oX_Max),
        .oY_Min        (oY_Min),
        .oY_Max        (oY_Max),
        .oX_Cent       (oX_Cent),
        .oY_Cent       (oY_Cent),
        .oFound        (oFound),
        .oResult_Valid (oResult_Valid),
        .oBusy         (oBusy),
        .oOverrun      (oOverrun)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: plain list reduction over the pixels the frame contained.
    function automatic exp_t model(input longint frameEndCycle);
        exp_t   e;
        longint cnt = 0, sx = 0, sy = 0;
        longint xmn = 65535, xmx = 0, ymn = 65535, ymx = 0;
        foreach (frameQ[i]) begin
            if (frameQ[i].dval && frameQ[i].skin) begin
                cnt++;
                sx += frameQ[i].x;
                sy += frameQ[i].y;
                if (frameQ[i].x < xmn) xmn = frameQ[i].x;
                if (frameQ[i].x > xmx) xmx = frameQ[i].x;
                if (frameQ[i].y < ymn) ymn = frameQ[i].y;
                if (frameQ[i].y > ymx) ymx = frameQ[i].y;
            end
        end
        e = '{count: cnt, xMin: 0, xMax: 0, yMin: 0, yMax: 0, xCent: 0, yCent: 0,
              found: 1'b0, due: frameEndCycle + 1};
        if (cnt >= MIN_PIXELS) begin
            e.found = 1'b1;
            e.xMin  = xmn;
            e.xMax  = xmx;
            e.yMin  = ymn;
            e.yMax  = ymx;
            e.xCent = sx / cnt;
            e.yCent = sy / cnt;
            e.due   = frameEndCycle + FOUND_LAT;
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit expectPublish);
        foreach (frameQ[i]) begin
            @(posedge iCLK); #1;
            iFrame_En = 1'b1;
            iDVAL     = frameQ[i].dval;
            iBinary   = frameQ[i].skin;
            iX_Cont   = X_W'(frameQ[i].x);
            iY_Cont   = Y_W'(frameQ[i].y);
        end
        @(posedge iCLK); #1;
        // A valid skin pixel at (0,0) on the edge cycle must be ignored.
        iFrame_En = 1'b0;
        iDVAL     = 1'b1;
        iBinary   = 1'b1;
        iX_Cont   = '0;
        iY_Cont   = '0;
        if (expectPublish) expQ.push_back(model(cycleCnt));
    endtask

    task automatic buildConst(input int n, input int x, input int y);
        frameQ.delete();
        repeat (n) frameQ.push_back('{x: x, y: y, dval: 1'b1, skin: 1'b1});
    endtask

    task automatic buildRandom(input int n, input int dvalPct, input int skinPct);
        frameQ.delete();
        repeat (n) frameQ.push_back('{x: int'($urandom_range(0, 639)), y: int'($urandom_range(0, 479)),
                                      dval: ($urandom_range(1, 100) <= dvalPct),
                                      skin: ($urandom_range(1, 100) <= skinPct)});
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(posedge iCLK);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL result_timeout: %0d results still pending, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(posedge iCLK);
    endtask

    task automatic checkAllZero(input string tag);
        @(negedge iCLK);
        checkOutput({tag, "_count"}, 64'(oCount), 0);
        checkOutput({tag, "_xmin"}, 64'(oX_Min), 0);
        checkOutput({tag, "_xmax"}, 64'(oX_Max), 0);
        checkOutput({tag, "_ymin"}, 64'(oY_Min), 0);
        checkOutput({tag, "_ymax"}, 64'(oY_Max), 0);
        checkOutput({tag, "_xcent"}, 64'(oX_Cent), 0);
        checkOutput({tag, "_ycent"}, 64'(oY_Cent), 0);
        checkOutput({tag, "_found"}, 64'(oFound), 0);
        checkOutput({tag, "_valid"}, 64'(oResult_Valid), 0);
        checkOutput({tag, "_busy"}, 64'(oBusy), 0);
        checkOutput({tag, "_overrun"}, 64'(oOverrun), 0);
    endtask

    // Monitor: every result pulse is matched against the oldest prediction.
    always @(negedge iCLK) begin
        if (!iRST && oResult_Valid) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: result pulse at cycle %0d, expected none", cycleCnt);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("latency", 64'(cycleCnt), 64'(e.due));
                checkOutput("count", 64'(oCount), 64'(e.count));
                checkOutput("found", 64'(oFound), 64'(e.found));
                checkOutput("x_min", 64'(oX_Min), 64'(e.xMin));
                checkOutput("x_max", 64'(oX_Max), 64'(e.xMax));
                checkOutput("y_min", 64'(oY_Min), 64'(e.yMin));
                checkOutput("y_max", 64'(oY_Max), 64'(e.yMax));
                checkOutput("x_cent", 64'(oX_Cent), 64'(e.xCent));
                checkOutput("y_cent", 64'(oY_Cent), 64'(e.yCent));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRST      = 1'b1;
        iBinary   = 1'b0;
        iDVAL     = 1'b0;
        iFrame_En = 1'b0;
        iX_Cont   = '0;
        iY_Cont   = '0;
        repeat (3) @(posedge iCLK); #1;
        iRST = 1'b0;
        checkAllZero("reset");

        // Single location: bbox degenerates to a point.
        buildConst(64, 10, 20);
        applyStimulus(1'b1);
        repeat (10) @(posedge iCLK);
        @(negedge iCLK);
        checkOutput("busy_mid_div", 64'(oBusy), 1);
        waitIdle();

        // Four corners of a 3x3 square.
        frameQ.delete();
        for (int i = 0; i < 64; i++)
            frameQ.push_back('{x: 100 + 2 * (i % 2), y: 50 + 2 * ((i / 2) % 2), dval: 1'b1, skin: 1'b1});
        applyStimulus(1'b1);
        waitIdle();

        // Centroid 1.5 truncates to 1.
        frameQ.delete();
        for (int i = 0; i < 64; i++) frameQ.push_back('{x: 1 + (i % 2), y: 0, dval: 1'b1, skin: 1'b1});
        applyStimulus(1'b1);
        waitIdle();

        // One short of the threshold.
        buildRandom(63, 100, 100);
        applyStimulus(1'b1);
        waitIdle();
        @(negedge iCLK);
        checkOutput("busy_idle", 64'(oBusy), 0);

        // Back-to-back frames, the second accumulating during the first's division.
        buildRandom(100, 100, 100);
        applyStimulus(1'b1);
        buildRandom(130, 90, 85);
        applyStimulus(1'b1);
        waitIdle();
        @(negedge iCLK);
        checkOutput("overrun_clear", 64'(oOverrun), 0);

        // Second frame ends at cycle 39, inside the X division.
        buildRandom(70, 100, 100);
        applyStimulus(1'b1);
        buildRandom(38, 100, 100);
        applyStimulus(1'b0);
        waitIdle();
        @(negedge iCLK);
        checkOutput("overrun_set", 64'(oOverrun), 1);

        for (int f = 0; f < 6; f++) begin
            buildRandom(int'($urandom_range(30, 160)), 80, 80);
            applyStimulus(1'b1);
            waitIdle();
            repeat ($urandom_range(0, 5)) @(posedge iCLK);
        end

        // Reset inside the Y division: no publish, everything back to zero.
        buildConst(80, 300, 200);
        applyStimulus(1'b1);
        repeat (60) @(posedge iCLK); #1;
        iRST = 1'b1;
        expQ.delete();
        repeat (2) @(posedge iCLK); #1;
        iRST = 1'b0;
        checkAllZero("rst_div");
        repeat (100) @(posedge iCLK);

        buildConst(64, 7, 9);
        applyStimulus(1'b1);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/skin_region_locator.md
# skin_region_locator

Downstream consumer of the skin-binarisation stage. Accumulates the per-pixel skin mask (1 = skin) over one frame, then publishes the frame's skin-pixel count, bounding box and integer centroid. The game-logic layer uses these values to locate the player's hand. Accumulation runs in parallel with the centroid divisions for the previous frame, so back-to-back frames do not stall.

## Interface
- X_W, 16, width of X coordinate
- Y_W, 16, width of Y coordinate
- CNT_W, 24, width of skin-pixel counter
- MIN_PIXELS, 64, minimum count for a frame to report an object
- iCLK  in  1  clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iBinary  in  1  skin mask bit, sampled only when iDVAL=1
- iDVAL  in  1  pixel valid
- iX_Cont  in  X_W  pixel column
- iY_Cont  in  Y_W  pixel row
- iFrame_En  in  1  high for the duration of an active frame
- oCount  out  CNT_W  skin pixels in last published frame
- oX_Min, oX_Max  out  X_W  bounding box columns
- oY_Min, oY_Max  out  Y_W  bounding box rows
- oX_Cent  out  X_W  floor(sum X / count)
- oY_Cent  out  Y_W  floor(sum Y / count)
- oFound  out  1  count ≥ MIN_PIXELS in last published frame
- oResult_Valid  out  1  one-cycle pulse when outputs update
- oBusy  out  1  division in progress
- oOverrun  out  1  sticky; a frame end arrived while busy

## Operation
- Accumulators: count (CNT_W), sumX (SX_W = X_W+CNT_W), sumY (SY_W = Y_W+CNT_W), xmin, xmax, ymin, ymax.
- Frame start: iFrame_En sampled 1 with previous sample 0.
  - Clears accumulators: count, sums and max = 0; min = all-ones.
  - If a skin pixel is valid in that same cycle, clear-and-add: the accumulators hold that pixel's contribution.
- Accumulate when iFrame_En=1, iDVAL=1 and iBinary=1:
  - count += 1; sumX += X; sumY += Y.
  - min/max updated by unsigned compare.
  - When count = 2^CNT_W−1, count and sums freeze. Min/max continue to update.
- iDVAL with iFrame_En=0 is ignored.
- Frame end: iFrame_En sampled 0 with previous sample 1. The edge cycle's pixel is ignored.
  - Accumulators are snapshotted into operand registers, so the next frame may start immediately.
- FSM states: IDLE, DIV_X, DIV_Y, PUBLISH.
  - IDLE → DIV_X on frame end when count ≥ MIN_PIXELS.
  - IDLE → PUBLISH on frame end when count < MIN_PIXELS. PUBLISH then writes: count, oFound=0, centroid=0, bbox=0.
  - DIV_X → DIV_Y on divider done.
  - DIV_Y → PUBLISH on divider done.
  - PUBLISH → IDLE unconditionally. Outputs are registered and oResult_Valid=1 in this state.
- oBusy = 1 in DIV_X and DIV_Y.
- A frame end while not in IDLE:
  - the frame's snapshot is discarded;
  - oOverrun is set;
  - the current computation completes unaffected.
- Outputs hold their values between publishes.

## Timing
- Reset: all outputs 0 and FSM = IDLE.
  - Accumulators and min/max are cleared to 0, not the frame-start min = all-ones pattern. They are therefore only meaningful after the next frame start.
  - Edge-detect history is cleared to 0, so iFrame_En already high when reset deasserts is seen as a frame start.
- Reset mid-division aborts the division with no publish.
- Cycle 0 is the frame-end edge cycle.
- Found case: oResult_Valid at cycle SX_W+SY_W+4 (84 with defaults).
  - Divider start pulses at cycles 1 and SX_W+2.
  - Each division takes SX_W (or SY_W) iterations plus 1 done cycle.
- Not-found case: oResult_Valid at cycle 1.
- A new frame end is accepted from the cycle after PUBLISH.

## Structure
- Package skin_pkg holds:
  - width constants (X_W, Y_W, CNT_W, SX_W, SY_W);
  - FSM state enum;
  - packed result struct (count, bbox, centroid, found).
- Sub-module seq_divider: restoring, one quotient bit per cycle, parameter N.
  - Ports: start, dividend[N], divisor[CNT_W], quotient[N], done.
  - Instantiated once and shared for X then Y. The quotient is truncated to X_W/Y_W.
- Target size: about 250 lines for the top level plus about 80 for seq_divider.

## Test plan
- MIN_PIXELS=1; single skin pixel at (10,20) → count=1, bbox (10,10,20,20), centroid (10,20), oFound=1, oResult_Valid at cycle 84.
- MIN_PIXELS=1; skin at x∈{100,102}, y∈{50,52} (4 pixels) → centroid (101,51), bbox (100,102,50,52).
- MIN_PIXELS=1; skin at x=1 and x=2 on row 0 → oX_Cent=1 (truncation).
- 63 skin pixels with default MIN_PIXELS → oFound=0, centroid 0, oCount=63, oResult_Valid at cycle 1.
- Start the next frame 1 cycle after frame end and keep accumulating during division → first result correct; second frame's result correct and independent.
- Frame end at cycle 40 of a division → oOverrun=1 and the first result still publishes; iRST during DIV_Y → no pulse, all outputs 0.
